// File: rtl/alu_serial_sequencer.sv
// Bit-serial ALU sequencer: one 1-bit slice, LSB first, carry held in a flop.
// Optional ALU_SEQ_OVERFLOW_EN adds an Overflow port and a signed-correct SLT.
module alu_serial_sequencer #(
  parameter int WIDTH = 24
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       Op,
  input  logic             AInvert,
  input  logic             BInvert,
  input  logic             CIN,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             CarryOut,
`ifdef ALU_SEQ_OVERFLOW_EN
  output logic             Overflow,
`endif
  output logic             Zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SLT = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;
  logic             ainv_q;
  logic             binv_q;
  logic [CW-1:0]    cnt;
  logic             carry;

  logic abit;
  logic bbit;
  logic sum;
  logic cnext;
  logic slice;
  logic last;
  logic set;

  assign abit  = a_q[cnt] ^ ainv_q;
  assign bbit  = b_q[cnt] ^ binv_q;
  assign sum   = abit ^ bbit ^ carry;
  assign cnext = (abit & bbit) | (abit & carry) | (bbit & carry);
  assign last  = (cnt == CW'(WIDTH - 1));

`ifdef ALU_SEQ_OVERFLOW_EN
  logic ovf_bit;
  assign ovf_bit = carry ^ cnext;
  assign set     = sum ^ ovf_bit;
`else
  assign set     = sum;
`endif

  always_comb begin
    slice = 1'b0;
    unique case (op_q)
      OP_AND:  slice = abit & bbit;
      OP_OR:   slice = abit | bbit;
      OP_ADD:  slice = sum;
      OP_SLT:  slice = 1'b0;
      OP_XOR:  slice = abit ^ bbit;
      default: slice = 1'b0;
    endcase
  end

  assign Zero = ~|Result;

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state    <= IDLE;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Result   <= '0;
      CarryOut <= 1'b0;
      cnt      <= '0;
      carry    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_AND;
      ainv_q   <= 1'b0;
      binv_q   <= 1'b0;
`ifdef ALU_SEQ_OVERFLOW_EN
      Overflow <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            a_q    <= A;
            b_q    <= B;
            op_q   <= Op;
            ainv_q <= AInvert;
            binv_q <= BInvert;
            carry  <= CIN;
            cnt    <= '0;
            Result <= '0;
            Busy   <= 1'b1;
            state  <= RUN;
`ifdef ALU_SEQ_OVERFLOW_EN
            Overflow <= 1'b0;
`endif
          end
        end
        RUN: begin
          carry <= cnext;
          cnt   <= cnt + 1'b1;
          // SLT bits are all zero in RUN; bit 0 gets the set flag at the end
          if (last && op_q == OP_SLT) begin
            Result[0] <= set;
          end else begin
            Result[cnt] <= slice;
          end
          if (last) begin
            CarryOut <= cnext;
            Done     <= 1'b1;
            state    <= FINISH;
`ifdef ALU_SEQ_OVERFLOW_EN
            Overflow <= ovf_bit;
`endif
          end
        end
        FINISH: begin
          Done  <= 1'b0;
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
